// File: rtl/io_uart_tx.sv
// io_uart_tx: watches the core's output register, queues every change of the
// word in a small FIFO and sends each queued word as four 8N1 UART bytes,
// least-significant byte first, on a single idle-high TX line.
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [31:0]                   data_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO and change-detect state
    logic [31:0]   prev_q;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q;
    logic          change, push, pop, drop;

    // Transmitter state
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   shift_q, shift_d;
    logic [7:0]    cur_byte;
    logic          bit_done;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    // Push/pop decisions and the next FIFO occupancy.
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        change  = (data_i != prev_q);
        pop     = (state_q == IDLE) && (level_q != '0);
        push    = change && ((level_q != LVL_FULL) || pop);
        drop    = change && !push;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Change detector, FIFO pointers, occupancy and sticky overflow flag.
    // NOTE: sequential state is updated with non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (change) prev_q <= data_i;
            if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            if (drop)   ovf_q <= 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    // NOTE: the storage array has no reset; emptiness is tracked by the pointers and level, which are reset.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= data_i;
    end

    // Next-state, baud counter and next TX level for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        bit_done = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    shift_d = mem[rd_ptr_q];
                    byte_d  = 2'd0;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 1'b1;
                        shift_d = shift_q >> 8;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // TX level follows the state being entered, so the line is a plain register.
        cur_byte = shift_d[7:0];
        tx_d     = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = cur_byte[bit_d];

        busy_d = (state_d != IDLE) || (level_d != '0);
    end

    // Frame sequencer registers, registered TX line and busy flag.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign level_o    = level_q;

endmodule
